// File: rtl/tricolor_pwm.sv
// tricolor_pwm: three-channel LED PWM driver with a one-deep command slot.
//
// A free-running counter cnt sweeps 0..P-1 (P = 2^PWM_BITS - 1). Each LED
// output is active-low and lit while cnt < active duty for that channel.
// Commands are taken into shadow registers and only copied to the active
// duties on a period boundary (the edge where cnt == P-1), so a channel
// never sees a partial period. The new color is then shown for at least
// max(hold,1) full periods before another command is accepted.
//
// Optional build macro: TRICOLOR_GAMMA_EN
//   When defined, each duty is shaped as (d*d + P) >> PWM_BITS before it is
//   latched into the shadow registers. Timing and handshake are unchanged.
//
// Handshake (valid/ready): a command transfers on a rising edge where
// i_cmd_valid and o_cmd_ready are both high. o_cmd_ready depends only on
// the FSM state and i_rst, never on i_cmd_valid. While o_cmd_ready is low,
// i_cmd_valid and the command data are ignored and nothing is sampled.
//
// o_dbg_state exposes the FSM state encoding (0 IDLE, 1 PEND, 2 SHOW).

module tricolor_pwm #(
  parameter int PWM_BITS  = 8,
  parameter int HOLD_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [PWM_BITS-1:0]  i_cmd_r,
  input  logic [PWM_BITS-1:0]  i_cmd_g,
  input  logic [PWM_BITS-1:0]  i_cmd_b,
  input  logic [HOLD_BITS-1:0] i_cmd_hold,
  output logic                 o_busy,
  output logic                 o_led_r,
  output logic                 o_led_g,
  output logic                 o_led_b,
  output logic [1:0]           o_dbg_state
);

  // P as a PWM_BITS-wide all-ones value, and the last counter value P-1.
  localparam logic [PWM_BITS-1:0] P_VAL    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  // Duty shaping applied at command acceptance.
  function automatic logic [PWM_BITS-1:0] shape_duty(input logic [PWM_BITS-1:0] d);
`ifdef TRICOLOR_GAMMA_EN
    logic [2*PWM_BITS-1:0] d_ext;
    logic [2*PWM_BITS-1:0] p_ext;
    logic [2*PWM_BITS-1:0] sq;
    // P*(P+1) < 2^(2*PWM_BITS), so the sum never overflows 2*PWM_BITS bits.
    d_ext = {{PWM_BITS{1'b0}}, d};
    p_ext = {{PWM_BITS{1'b0}}, P_VAL};
    sq    = (d_ext * d_ext) + p_ext;
    return PWM_BITS'(sq >> PWM_BITS);
`else
    return d;
`endif
  endfunction

  state_t               state_q, state_d;
  logic [PWM_BITS-1:0]  cnt_q, cnt_d;
  logic [PWM_BITS-1:0]  shd_r_q, shd_r_d;
  logic [PWM_BITS-1:0]  shd_g_q, shd_g_d;
  logic [PWM_BITS-1:0]  shd_b_q, shd_b_d;
  logic [PWM_BITS-1:0]  act_r_q, act_r_d;
  logic [PWM_BITS-1:0]  act_g_q, act_g_d;
  logic [PWM_BITS-1:0]  act_b_q, act_b_d;
  logic [HOLD_BITS-1:0] hold_reg_q, hold_reg_d;
  logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;

  logic                 boundary;
  logic                 accept;
  logic [HOLD_BITS-1:0] hold_eff;

  assign boundary = (cnt_q == CNT_LAST);
  assign accept   = i_cmd_valid & o_cmd_ready;
  // A hold of zero still shows the color for one full period.
  assign hold_eff = (hold_reg_q == '0) ? HOLD_BITS'(1) : hold_reg_q;

  // Period counter: free-running in every state, wraps after P-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (boundary) begin
      cnt_d = '0;
    end
  end

  // Command FSM and duty/hold register updates.
  always_comb begin
    state_d    = state_q;
    shd_r_d    = shd_r_q;
    shd_g_d    = shd_g_q;
    shd_b_d    = shd_b_q;
    act_r_d    = act_r_q;
    act_g_d    = act_g_q;
    act_b_d    = act_b_q;
    hold_reg_d = hold_reg_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Only IDLE samples the command; a boundary on this same edge is
        // not used, PEND waits for the following one.
        if (accept) begin
          shd_r_d    = shape_duty(i_cmd_r);
          shd_g_d    = shape_duty(i_cmd_g);
          shd_b_d    = shape_duty(i_cmd_b);
          hold_reg_d = i_cmd_hold;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          act_r_d    = shd_r_q;
          act_g_d    = shd_g_q;
          act_b_d    = shd_b_q;
          hold_cnt_d = hold_eff;
          state_d    = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (boundary) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
          if (hold_cnt_q == HOLD_BITS'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shd_r_q    <= '0;
      shd_g_q    <= '0;
      shd_b_q    <= '0;
      act_r_q    <= '0;
      act_g_q    <= '0;
      act_b_q    <= '0;
      hold_reg_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shd_r_q    <= shd_r_d;
      shd_g_q    <= shd_g_d;
      shd_b_q    <= shd_b_d;
      act_r_q    <= act_r_d;
      act_g_q    <= act_g_d;
      act_b_q    <= act_b_d;
      hold_reg_q <= hold_reg_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs: ready is held low during reset; LEDs are active-low compares
  // of registered values, so duty 0 is never lit and duty P always lit.
  assign o_cmd_ready = (state_q == ST_IDLE) & ~i_rst;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_led_r     = ~(cnt_q < act_r_q);
  assign o_led_g     = ~(cnt_q < act_g_q);
  assign o_led_b     = ~(cnt_q < act_b_q);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tricolor_pwm.sv
// Bench for tricolor_pwm (PWM_BITS = 8, P = 255). Covers reset, table
// vectors for latency/hold/duty, reset during SHOW, and random traffic
// against an event-time reference model.

module tb_tricolor_pwm;

  localparam int PW = 8;
  localparam int HW = 16;
  localparam int P  = 255;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [PW-1:0] i_cmd_r = '0;
  logic [PW-1:0] i_cmd_g = '0;
  logic [PW-1:0] i_cmd_b = '0;
  logic [HW-1:0] i_cmd_hold = '0;
  logic          o_busy;
  logic          o_led_r, o_led_g, o_led_b;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  tricolor_pwm #(.PWM_BITS(PW), .HOLD_BITS(HW)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_r     (i_cmd_r),
    .i_cmd_g     (i_cmd_g),
    .i_cmd_b     (i_cmd_b),
    .i_cmd_hold  (i_cmd_hold),
    .o_busy      (o_busy),
    .o_led_r     (o_led_r),
    .o_led_g     (o_led_g),
    .o_led_b     (o_led_b),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in absolute edge numbers: g counts edges since reset, cnt = g % P.
  // An accept schedules the time the new duties appear and the time the
  // command finishes, straight from the latency/hold rules.
  bit m_init = 1'b0;
  int m_g    = 0;
  bit m_busy = 1'b0;
  int m_apply, m_end;
  int m_shd[3];
  int m_act[3];

  function automatic int gam(input int d);
`ifdef TRICOLOR_GAMMA_EN
    return (d * d + P) >> PW;
`else
    return d;
`endif
  endfunction

  task automatic model_edge();
    int c, h;
    if (i_rst) begin
      m_init = 1'b1;
      m_g    = 0;
      m_busy = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_shd[k] = 0;
        m_act[k] = 0;
      end
    end else if (m_init) begin
      c = m_g % P;
      if (m_busy) begin
        if (m_g == m_apply) for (int k = 0; k < 3; k++) m_act[k] = m_shd[k];
        if (m_g == m_end) m_busy = 1'b0;
      end else if (i_cmd_valid) begin
        m_busy   = 1'b1;
        m_shd[0] = gam(int'(i_cmd_r));
        m_shd[1] = gam(int'(i_cmd_g));
        m_shd[2] = gam(int'(i_cmd_b));
        h        = (i_cmd_hold == 0) ? 1 : int'(i_cmd_hold);
        m_apply  = m_g + ((c < P - 1) ? (P - 1 - c) : P);
        m_end    = m_apply + h * P;
      end
      m_g++;
    end
  endtask

  task automatic check_outputs();
    int c;
    if (m_init) begin
      c = m_g % P;
      chk("led_r", {31'd0, o_led_r}, (c < m_act[0]) ? 0 : 1);
      chk("led_g", {31'd0, o_led_g}, (c < m_act[1]) ? 0 : 1);
      chk("led_b", {31'd0, o_led_b}, (c < m_act[2]) ? 0 : 1);
      chk("busy",  {31'd0, o_busy},  {31'd0, m_busy});
      chk("ready", {31'd0, o_cmd_ready}, (!m_busy && !i_rst) ? 1 : 0);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with inputs already set: check, clock, update model.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    i_cmd_valid = 1'b0;
    while ((m_busy || (m_g % P) != c) && n < 3 * P) begin
      tick();
      n++;
    end
    chk("wait_cnt_reached", (n < 3 * P) ? 1 : 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int r, g, b, hold, start_cnt;
    bit keep_valid;
    int exp_busy;
    int exp_lit_r, exp_lit_g, exp_lit_b;
  } vec_t;

  vec_t vecs[4];

  bit hist_r[$], hist_g[$], hist_b[$];

  initial begin
    int n, lr, lg, lb;

    vecs[0] = '{r:255, g:0,   b:0,   hold:2, start_cnt:10,  keep_valid:0, exp_busy:754,
                exp_lit_r:255, exp_lit_g:0, exp_lit_b:0};
    vecs[1] = '{r:0,   g:64,  b:0,   hold:1, start_cnt:0,   keep_valid:0, exp_busy:509,
                exp_lit_r:0, exp_lit_g:64, exp_lit_b:0};
    vecs[2] = '{r:17,  g:200, b:254, hold:0, start_cnt:254, keep_valid:1, exp_busy:510,
                exp_lit_r:17, exp_lit_g:200, exp_lit_b:254};
    vecs[3] = '{r:128, g:1,   b:100, hold:3, start_cnt:100, keep_valid:1, exp_busy:919,
                exp_lit_r:128, exp_lit_g:1, exp_lit_b:100};
`ifdef TRICOLOR_GAMMA_EN
    vecs[1].exp_lit_g = 16;
    vecs[2].exp_lit_r = 2;
    vecs[2].exp_lit_g = 157;
    vecs[2].exp_lit_b = 253;
    vecs[3].exp_lit_r = 64;
    vecs[3].exp_lit_g = 1;
    vecs[3].exp_lit_b = 40;
`endif

    // Reset held for three cycles.
    @(negedge clk);
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, o_cmd_ready}, 1);
    chk("busy_after_rst",  {31'd0, o_busy}, 0);
    chk("led_r_after_rst", {31'd0, o_led_r}, 1);
    chk("led_g_after_rst", {31'd0, o_led_g}, 1);
    chk("led_b_after_rst", {31'd0, o_led_b}, 1);
    tick();

    // Table vectors: latency + hold via busy length, duty via lit count
    // over the final full SHOW period.
    for (int v = 0; v < 4; v++) begin
      wait_cnt(vecs[v].start_cnt);
      i_cmd_valid = 1'b1;
      i_cmd_r     = PW'(vecs[v].r);
      i_cmd_g     = PW'(vecs[v].g);
      i_cmd_b     = PW'(vecs[v].b);
      i_cmd_hold  = HW'(vecs[v].hold);
      tick();
      hist_r.delete(); hist_g.delete(); hist_b.delete();
      n = 0;
      while (o_busy === 1'b1 && n < 2000) begin
        hist_r.push_back(!o_led_r);
        hist_g.push_back(!o_led_g);
        hist_b.push_back(!o_led_b);
        if (hist_r.size() > P) begin
          void'(hist_r.pop_front()); void'(hist_g.pop_front()); void'(hist_b.pop_front());
        end
        i_cmd_valid = vecs[v].keep_valid;
        i_cmd_r     = PW'($urandom_range(0, 255));
        i_cmd_g     = PW'($urandom_range(0, 255));
        i_cmd_b     = PW'($urandom_range(0, 255));
        i_cmd_hold  = HW'($urandom_range(0, 5));
        tick();
        n++;
      end
      i_cmd_valid = 1'b0;
      lr = 0; lg = 0; lb = 0;
      foreach (hist_r[k]) begin
        lr += int'(hist_r[k]);
        lg += int'(hist_g[k]);
        lb += int'(hist_b[k]);
      end
      chk("vec_busy_len", n, vecs[v].exp_busy);
      chk("vec_lit_r", lr, vecs[v].exp_lit_r);
      chk("vec_lit_g", lg, vecs[v].exp_lit_g);
      chk("vec_lit_b", lb, vecs[v].exp_lit_b);
      // IDLE keeps showing the last color for a further period.
      repeat (P) tick();
    end

    // Reset pulsed mid-SHOW: command is dropped, LEDs go dark.
    wait_cnt(30);
    i_cmd_valid = 1'b1;
    i_cmd_r = 8'd200; i_cmd_g = 8'd50; i_cmd_b = 8'd10; i_cmd_hold = 16'd3;
    tick();
    i_cmd_valid = 1'b0;
    n = 0;
    while (!(m_busy && m_g > m_apply + 20) && n < 2 * P) begin
      tick();
      n++;
    end
    chk("reach_show", {31'd0, o_busy}, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, o_busy}, 0);
    chk("mid_rst_ready", {31'd0, o_cmd_ready}, 1);
    chk("mid_rst_led_r", {31'd0, o_led_r}, 1);
    chk("mid_rst_led_g", {31'd0, o_led_g}, 1);
    chk("mid_rst_led_b", {31'd0, o_led_b}, 1);
    repeat (2 * P) tick();
    chk("no_resume_busy", {31'd0, o_busy}, 0);

    // Random traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      i_rst       = ($urandom_range(0, 1499) == 0);
      i_cmd_valid = ($urandom_range(0, 3) == 0);
      i_cmd_r     = PW'($urandom_range(0, 255));
      i_cmd_g     = PW'($urandom_range(0, 255));
      i_cmd_b     = PW'($urandom_range(0, 255));
      i_cmd_hold  = HW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) i_cmd_r = '1;
      if ($urandom_range(0, 7) == 0) i_cmd_g = '0;
      tick();
    end
    i_rst = 1'b0;
    i_cmd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
